distance_filter: RTL and testbench
==================================

// Module: distance_filter
// PURPOSE
//  Post-processing stage directly downstream of the ultrasonic ranging driver.
//  Captures each 12-bit distance sample on the driver's one-cycle end-of-echo strobe.
//  Rejects out-of-range samples and keeps a 2^LOG2_N-sample moving average.
//  Drives a hysteresis "object near" alarm and a stale-data flag for the display/control logic.
// PARAMETERS
//  DW           12         sample / average width (bits)
//  LOG2_N       3          log2 of averaging window depth (window = 8 samples)
//  MAX_VALID    12'd4000   largest accepted sample; 0 and >MAX_VALID are rejected
//  NEAR_TH      12'd300    alarm sets when average < NEAR_TH
//  HYST         12'd20     alarm clears when average >= NEAR_TH+HYST
//  TIMEOUT_CYC  6_000_000  clk cycles without an accepted sample before stale
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous, active-high reset
//  sample_in    in   DW      distance sample, valid in the sample_stb cycle
//  sample_stb   in   1       one-cycle strobe from ranging driver (end of echo)
//  avg_out      out  DW      windowed average, held between updates
//  avg_valid    out  1       one-cycle pulse: avg_out/alarm just updated
//  alarm        out  1       object-near flag with hysteresis
//  stale        out  1       no accepted sample for TIMEOUT_CYC cycles
//  rejected     out  1       one-cycle pulse: sample discarded (range)
//  overrun      out  1       one-cycle pulse: strobe arrived while busy
// BEHAVIOUR
//  Reset: all outputs 0; buffer entries, sum, write ptr, fill count and timeout count = 0.
//  FSM IDLE -> ACCUM -> OUTPUT -> IDLE.
//   IDLE: on sample_stb, latch sample_in.
//     In range (1..MAX_VALID): go to ACCUM.
//     Out of range: rejected=1 next cycle; stay IDLE; buffer and timeout untouched.
//   ACCUM (1 cycle): sum <= sum - buf[wp] + s; buf[wp] <= s; wp <= wp+1 (mod 2^LOG2_N).
//     fill <= sat(fill+1, 2^LOG2_N).
//     Timeout counter cleared; stale cleared.
//   OUTPUT (1 cycle): if fill == 2^LOG2_N, then:
//     avg_out <= sum >> LOG2_N (truncate).
//     avg_valid = 1 in the following cycle.
//     Alarm is updated in the same cycle as avg_out.
//     If fill < 2^LOG2_N (warm-up), no avg_valid and avg_out is held.
//  Latency: avg_valid rises exactly 3 cycles after the accepted sample_stb cycle.
//  Sum register is DW+LOG2_N bits wide; it never overflows.
//  Strobe while in ACCUM/OUTPUT: the sample is dropped and overrun=1 next cycle; no other effect.
//  Alarm is evaluated only on an average update.
//   Set when avg < NEAR_TH.
//   Clear when avg >= NEAR_TH+HYST.
//   Otherwise hold.
//  Timeout: the counter increments each cycle while not stale.
//   On reaching TIMEOUT_CYC-1: stale=1 next cycle; counter holds.
//   Also: sum, fill and all buffer entries are flushed to 0; alarm is cleared.
//   avg_out is held; warm-up restarts.
//  Timeout reached in the same cycle as an accepted strobe: the strobe wins and stale stays 0.
//  rst asserted mid-operation: FSM -> IDLE; any in-flight sample is discarded; all state resets.
// TESTING
//  1. 8 strobes of 500 -> no avg_valid for the first 7.
//     After the 8th: avg_valid 3 cycles later, avg_out=500, alarm=0.
//  2. Warm window at 500, then 8 samples of 250 -> avg falls.
//     alarm=1 on the first update with avg<300.
//     Samples of 310 -> alarm stays 1 (310 < 320).
//     Samples of 320 -> alarm=0 on the first avg>=320.
//  3. sample_in=0 and sample_in=4001 -> rejected pulse each; avg_out/fill unchanged.
//     sample_in=4000 is accepted.
//  4. Second strobe 1 and 2 cycles after an accepted strobe -> overrun pulse each.
//     Average reflects only the first sample.
//  5. TIMEOUT_CYC=100, no strobes -> stale=1 at cycle 100 and alarm=0.
//     The next 7 strobes give no avg_valid.
//     The 1st strobe clears stale.
//  6. rst pulsed during ACCUM -> no avg_valid; all outputs 0.
//     A fresh warm-up is required.

Source files
------------

// File: rtl/distance_filter.sv
// ---------------------------------------------------------------------------
// distance_filter
//
// Post-processing stage that sits directly after the ultrasonic ranging
// driver. The module captures each distance sample on the driver's one-cycle
// end-of-echo strobe and discards samples that are out of range. It keeps a
// moving average over the last 2^LOG2_N accepted samples. From that average
// it drives an "object near" alarm with hysteresis, and it raises a stale
// flag when no sample has been accepted for a long time.
//
// Ports
//   clk         in   1    system clock
//   rst         in   1    synchronous, active-high reset
//   sample_in   in   DW   distance sample, valid in the sample_stb cycle
//   sample_stb  in   1    one-cycle strobe from the ranging driver
//   avg_out     out  DW   windowed average, held between updates
//   avg_valid   out  1    one-cycle pulse: avg_out/alarm just updated
//   alarm       out  1    object-near flag with hysteresis
//   stale       out  1    no accepted sample for TIMEOUT_CYC cycles
//   rejected    out  1    one-cycle pulse: sample discarded (out of range)
//   overrun     out  1    one-cycle pulse: strobe arrived while busy
//
// Handshake: the module has no back-pressure. A strobe in IDLE is always
// taken. A strobe in ACCUM or OUTPUT is dropped and flagged on overrun in
// the following cycle. Every output pulse lasts exactly one cycle.
// ---------------------------------------------------------------------------
module distance_filter #(
    parameter int             DW          = 12,
    parameter int             LOG2_N      = 3,
    parameter logic [DW-1:0]  MAX_VALID   = 12'd4000,
    parameter logic [DW-1:0]  NEAR_TH     = 12'd300,
    parameter logic [DW-1:0]  HYST        = 12'd20,
    parameter int             TIMEOUT_CYC = 6_000_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_stb,
    output logic [DW-1:0] avg_out,
    output logic          avg_valid,
    output logic          alarm,
    output logic          stale,
    output logic          rejected,
    output logic          overrun
);

    localparam int DEPTH = 1 << LOG2_N;
    localparam int SW    = DW + LOG2_N;
    localparam int TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [LOG2_N:0] FULL     = {1'b1, {LOG2_N{1'b0}}};
    localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT_CYC - 1);
    // One bit wider than the average, so NEAR_TH + HYST cannot wrap.
    localparam logic [DW:0]     CLEAR_TH = {1'b0, NEAR_TH} + {1'b0, HYST};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t state, state_n;

    logic [DW-1:0]     s_reg;
    logic [DW-1:0]     win_mem [DEPTH];
    logic [SW-1:0]     sum;
    logic [LOG2_N-1:0] wp;
    logic [LOG2_N:0]   fill;
    logic [TW-1:0]     tcnt;

    logic          in_range;
    logic          accept;
    logic          timeout_hit;
    logic [DW-1:0] new_avg;

    assign in_range = (sample_in != '0) && (sample_in <= MAX_VALID);
    assign accept   = (state == IDLE) && sample_stb && in_range;
    assign new_avg  = sum[SW-1:LOG2_N];

    // Accepted strobes and the ACCUM cycle both restart the timeout. The
    // timeout therefore cannot fire in the cycle a strobe is accepted.
    assign timeout_hit = !stale && !accept && (state != ACCUM) && (tcnt == TO_LAST);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = ACCUM;
            ACCUM:   state_n = OUTPUT;
            OUTPUT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Capture, pulse outputs and window accumulation
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg     <= '0;
            sum       <= '0;
            wp        <= '0;
            fill      <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
            alarm     <= 1'b0;
            rejected  <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                win_mem[i] <= '0;
            end
        end else begin
            avg_valid <= 1'b0;
            rejected  <= 1'b0;
            overrun   <= 1'b0;

            if (state == IDLE && sample_stb) begin
                s_reg    <= sample_in;
                rejected <= !in_range;
            end

            if (state != IDLE && sample_stb) begin
                overrun <= 1'b1;
            end

            // The running sum swaps the oldest entry for the new sample.
            // The window holds at most DEPTH samples of DW bits, so SW bits
            // are always enough.
            if (state == ACCUM) begin
                sum         <= sum - {{LOG2_N{1'b0}}, win_mem[wp]}
                                   + {{LOG2_N{1'b0}}, s_reg};
                win_mem[wp] <= s_reg;
                wp          <= wp + 1'b1;
                if (fill != FULL) begin
                    fill <= fill + 1'b1;
                end
            end

            // During warm-up, avg_out and alarm keep their previous values.
            if (state == OUTPUT && fill == FULL) begin
                avg_out   <= new_avg;
                avg_valid <= 1'b1;
                if (new_avg < NEAR_TH) begin
                    alarm <= 1'b1;
                end else if ({1'b0, new_avg} >= CLEAR_TH) begin
                    alarm <= 1'b0;
                end
            end

            // A timeout flushes the window so that warm-up restarts. This
            // assignment comes last so that it overrides the updates above.
            if (timeout_hit) begin
                sum   <= '0;
                fill  <= '0;
                alarm <= 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    win_mem[i] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Timeout / stale tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt  <= '0;
            stale <= 1'b0;
        end else if (state == ACCUM) begin
            tcnt  <= '0;
            stale <= 1'b0;
        end else if (accept) begin
            tcnt <= '0;
        end else if (timeout_hit) begin
            stale <= 1'b1;
        end else if (!stale) begin
            tcnt <= tcnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_distance_filter.sv
// ---------------------------------------------------------------------------
// tb_distance_filter
//
// Directed bench for distance_filter. It uses a shortened timeout
// (TIMEOUT_CYC = 100). The first part is a table of single-strobe vectors
// with hand-computed averages, alarm state and reject pulses. Hand-written
// sequences then cover overrun, timeout/flush and reset during ACCUM.
// ---------------------------------------------------------------------------
module tb_distance_filter;

  logic        clk;
  logic        rst;
  logic [11:0] sample_in;
  logic        sample_stb;
  logic [11:0] avg_out;
  logic        avg_valid;
  logic        alarm;
  logic        stale;
  logic        rejected;
  logic        overrun;

  int n_cmp;
  int n_fail;

  distance_filter #(
    .DW(12), .LOG2_N(3), .MAX_VALID(12'd4000), .NEAR_TH(12'd300),
    .HYST(12'd20), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_stb(sample_stb),
    .avg_out(avg_out), .avg_valid(avg_valid), .alarm(alarm), .stale(stale),
    .rejected(rejected), .overrun(overrun)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic [11:0] s;
    logic        v;
    logic [11:0] avg;
    logic        al;
    logic        rej;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [11:0] s, input logic v,
                              input logic [11:0] avg, input logic al,
                              input logic rej);
    vec_t e;
    e.s = s; e.v = v; e.avg = avg; e.al = al; e.rej = rej;
    tbl.push_back(e);
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    sample_in  = '0;
    sample_stb = 1'b0;
    rst        = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Strobe in cycle T, then return sampled at T+3, where avg_valid is due.
  task automatic send(input logic [11:0] s, output logic early, output logic v3,
                      output logic rej1, output logic ovr);
    sample_in  = s;
    sample_stb = 1'b1;
    @(posedge clk); #1;
    sample_stb = 1'b0;
    rej1  = rejected;
    early = avg_valid;
    ovr   = overrun;
    @(posedge clk); #1;
    early = early | avg_valid;
    ovr   = ovr | overrun;
    @(posedge clk); #1;
    v3  = avg_valid;
    ovr = ovr | overrun;
  endtask

  task automatic send_n(input logic [11:0] s, input int n, input string tag);
    logic e, v, r, o;
    for (int i = 0; i < n; i++) begin
      send(s, e, v, r, o);
      chk($sformatf("%s_%0d_valid", tag, i), {31'd0, v}, 32'd0);
      chk($sformatf("%s_%0d_early", tag, i), {31'd0, e}, 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic e, v, r, o;
    logic [11:0] avg_b;
    int n;
    n_cmp  = 0;
    n_fail = 0;
    rst = 1'b1;
    sample_in = '0;
    sample_stb = 1'b0;

    // Warm-up at 500 (test 1).
    for (int i = 0; i < 7; i++) add(12'd500, 1'b0, 12'd0, 1'b0, 1'b0);
    add(12'd500, 1'b1, 12'd500, 1'b0, 1'b0);
    // Eight samples of 250: alarm sets once the average drops below 300.
    add(12'd250, 1'b1, 12'd468, 1'b0, 1'b0);
    add(12'd250, 1'b1, 12'd437, 1'b0, 1'b0);
    add(12'd250, 1'b1, 12'd406, 1'b0, 1'b0);
    add(12'd250, 1'b1, 12'd375, 1'b0, 1'b0);
    add(12'd250, 1'b1, 12'd343, 1'b0, 1'b0);
    add(12'd250, 1'b1, 12'd312, 1'b0, 1'b0);
    add(12'd250, 1'b1, 12'd281, 1'b1, 1'b0);
    add(12'd250, 1'b1, 12'd250, 1'b1, 1'b0);
    // Samples of 310: the average stays below 320, so the alarm holds.
    add(12'd310, 1'b1, 12'd257, 1'b1, 1'b0);
    add(12'd310, 1'b1, 12'd265, 1'b1, 1'b0);
    add(12'd310, 1'b1, 12'd272, 1'b1, 1'b0);
    add(12'd310, 1'b1, 12'd280, 1'b1, 1'b0);
    add(12'd310, 1'b1, 12'd287, 1'b1, 1'b0);
    add(12'd310, 1'b1, 12'd295, 1'b1, 1'b0);
    add(12'd310, 1'b1, 12'd302, 1'b1, 1'b0);
    add(12'd310, 1'b1, 12'd310, 1'b1, 1'b0);
    // Samples of 320: the alarm clears on the first average >= 320.
    add(12'd320, 1'b1, 12'd311, 1'b1, 1'b0);
    add(12'd320, 1'b1, 12'd312, 1'b1, 1'b0);
    add(12'd320, 1'b1, 12'd313, 1'b1, 1'b0);
    add(12'd320, 1'b1, 12'd315, 1'b1, 1'b0);
    add(12'd320, 1'b1, 12'd316, 1'b1, 1'b0);
    add(12'd320, 1'b1, 12'd317, 1'b1, 1'b0);
    add(12'd320, 1'b1, 12'd318, 1'b1, 1'b0);
    add(12'd320, 1'b1, 12'd320, 1'b0, 1'b0);
    // Range limits: 0 and 4001 are rejected, 4000 is accepted.
    add(12'd0,    1'b0, 12'd320, 1'b0, 1'b1);
    add(12'd4001, 1'b0, 12'd320, 1'b0, 1'b1);
    add(12'd4000, 1'b1, 12'd780, 1'b0, 1'b0);

    // ---- reset state ----
    do_reset();
    chk("rst_avg_out",   {20'd0, avg_out}, 32'd0);
    chk("rst_avg_valid", {31'd0, avg_valid}, 32'd0);
    chk("rst_alarm",     {31'd0, alarm}, 32'd0);
    chk("rst_stale",     {31'd0, stale}, 32'd0);
    chk("rst_rejected",  {31'd0, rejected}, 32'd0);
    chk("rst_overrun",   {31'd0, overrun}, 32'd0);

    // ---- table-driven vectors ----
    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i].s, e, v, r, o);
      chk($sformatf("vec%0d_valid", i),   {31'd0, v}, {31'd0, tbl[i].v});
      chk($sformatf("vec%0d_early", i),   {31'd0, e}, 32'd0);
      chk($sformatf("vec%0d_avg", i),     {20'd0, avg_out}, {20'd0, tbl[i].avg});
      chk($sformatf("vec%0d_alarm", i),   {31'd0, alarm}, {31'd0, tbl[i].al});
      chk($sformatf("vec%0d_rej", i),     {31'd0, r}, {31'd0, tbl[i].rej});
      chk($sformatf("vec%0d_overrun", i), {31'd0, o}, 32'd0);
    end

    // ---- overrun: extra strobes in ACCUM and in OUTPUT ----
    do_reset();
    send_n(12'd500, 7, "ovr_warm");
    sample_in = 12'd100; sample_stb = 1'b1;
    @(posedge clk); #1;                       // ACCUM
    sample_in = 12'd4000;
    chk("ovr_none_T1", {31'd0, overrun}, 32'd0);
    @(posedge clk); #1;                       // OUTPUT
    chk("ovr_pulse_1", {31'd0, overrun}, 32'd1);
    @(posedge clk); #1;                       // IDLE
    sample_stb = 1'b0;
    chk("ovr_pulse_2", {31'd0, overrun}, 32'd1);
    chk("ovr_valid",   {31'd0, avg_valid}, 32'd1);
    chk("ovr_avg",     {20'd0, avg_out}, 32'd450);
    @(posedge clk); #1;
    chk("ovr_pulse_end", {31'd0, overrun}, 32'd0);
    chk("ovr_valid_end", {31'd0, avg_valid}, 32'd0);

    // ---- timeout: set the alarm, then wait for stale ----
    do_reset();
    send_n(12'd250, 7, "to_warm");
    send(12'd250, e, v, r, o);
    chk("to_pre_valid", {31'd0, v}, 32'd1);
    chk("to_pre_alarm", {31'd0, alarm}, 32'd1);
    n = 0;
    while (stale !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("to_stale_set", {31'd0, stale}, 32'd1);
    chk("to_cycles",    n, 32'd99);
    chk("to_alarm_clr", {31'd0, alarm}, 32'd0);
    chk("to_avg_held",  {20'd0, avg_out}, 32'd250);
    send(12'd250, e, v, r, o);
    chk("to_first_valid", {31'd0, v}, 32'd0);
    chk("to_stale_clr",   {31'd0, stale}, 32'd0);
    send_n(12'd250, 6, "to_rewarm");
    send(12'd250, e, v, r, o);
    chk("to_8th_valid", {31'd0, v}, 32'd1);
    chk("to_8th_avg",   {20'd0, avg_out}, 32'd250);
    chk("to_8th_alarm", {31'd0, alarm}, 32'd1);

    // ---- reset during ACCUM ----
    do_reset();
    send_n(12'd250, 7, "rs_warm");
    send(12'd250, e, v, r, o);
    chk("rs_pre_avg", {20'd0, avg_out}, 32'd250);
    sample_in = 12'd250; sample_stb = 1'b1;
    @(posedge clk); #1;                       // ACCUM
    sample_stb = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rs_avg_out", {20'd0, avg_out}, 32'd0);
    chk("rs_alarm",   {31'd0, alarm}, 32'd0);
    chk("rs_stale",   {31'd0, stale}, 32'd0);
    chk("rs_rej",     {31'd0, rejected}, 32'd0);
    chk("rs_ovr",     {31'd0, overrun}, 32'd0);
    v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = v | avg_valid;
      @(posedge clk); #1;
    end
    chk("rs_no_valid", {31'd0, v}, 32'd0);
    send_n(12'd400, 7, "rs_rewarm");
    avg_b = avg_out;
    chk("rs_rewarm_held", {20'd0, avg_b}, 32'd0);
    send(12'd400, e, v, r, o);
    chk("rs_8th_valid", {31'd0, v}, 32'd1);
    chk("rs_8th_avg",   {20'd0, avg_out}, 32'd400);

    // ---- report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog: a hung sequence still ends with a summary.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
